glitc_config_ctrl: RTL and testbench

Per-GLITC configuration sequencer that sits directly upstream of the quad GLITCBUS master. It drives PROGRAM_B and INIT_B for each of the four GLITC FPGAs and watches their DONE pins. It produces the gready[3:0] vector that tells the master whether to route a GLITC's accesses as configuration loads (gready=0) or as GLITCBUS transactions (gready=1). Software controls it through a small Wishbone slave in the TISC address space.

---
 rtl/glitc_config_ctrl_if.sv | 24 ++
 rtl/glitc_config_ctrl.sv | 138 +++++++++++++
 tb/tb_glitc_config_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitc_config_ctrl_if.sv
// Wishbone slave bus between TISC software and the GLITC configuration sequencer.
// Signal names carry the slave's direction suffixes.
interface glitc_config_ctrl_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/glitc_config_ctrl.sv
// Per-GLITC configuration sequencer: drives PROGRAM_B/INIT_B, watches DONE and
// tells the GLITCBUS master (gready) which GLITCs are configured.
module glitc_config_ctrl #(
  parameter int unsigned PROG_CYCLES      = 64,
  parameter int unsigned INIT_HOLD_CYCLES = 64,
  parameter int unsigned INIT_TIMEOUT     = 65535,
  parameter int unsigned DONE_TIMEOUT     = 16777215,
  parameter int unsigned CNT_WIDTH        = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  glitc_config_ctrl_if.slave  wb,
  output logic [3:0]          program_b_o,
  output logic [3:0]          init_b_oe_o,
  input  logic [3:0]          init_b_i,
  input  logic [3:0]          done_i,
  output logic [3:0]          gready_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PROG      = 3'd1;
  localparam logic [2:0] S_INIT_HOLD = 3'd2;
  localparam logic [2:0] S_WAIT_INIT = 3'd3;
  localparam logic [2:0] S_LOADING   = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  localparam logic [CNT_WIDTH-1:0] PROG_LAST = CNT_WIDTH'(PROG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(INIT_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] INIT_TO   = CNT_WIDTH'(INIT_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] DONE_TO   = CNT_WIDTH'(DONE_TIMEOUT);

  logic [3:0] done_m_q, done_s, init_m_q, init_s;
  logic [3:0][2:0] state_q, state_d;
  logic [3:0][CNT_WIDTH-1:0] timer_q, timer_d;
  logic [3:0] err_flag_q, err_flag_d, err_set, busy;
  logic [3:0] program_b_q, init_oe_q, gready_q;
  logic       post_rst_q;
  logic       ack_q, wr_q, req;
  logic [1:0] wadr_q;
  logic [3:0] wdat_q, start, errclr;
  logic [31:0] dat_q, rd_data;
  logic       unused_ok;

  // Synchronizers are left out of reset so DONE is already valid when reset falls.
  always_ff @(posedge clk_i) begin
    done_m_q <= done_i;
    done_s   <= done_m_q;
    init_m_q <= init_b_i;
    init_s   <= init_m_q;
  end

  assign req    = wb.cyc_i & wb.stb_i & ~ack_q;
  assign start  = (ack_q && wr_q && wadr_q == 2'd0) ? wdat_q : 4'h0;
  assign errclr = (ack_q && wr_q && wadr_q == 2'd2) ? wdat_q : 4'h0;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      case (state_q[n])
        S_IDLE:      if (post_rst_q && done_s[n]) state_d[n] = S_READY;
        S_PROG:      if (timer_q[n] == PROG_LAST) state_d[n] = S_INIT_HOLD;
        S_INIT_HOLD: if (timer_q[n] == HOLD_LAST) state_d[n] = S_WAIT_INIT;
        S_WAIT_INIT: if (init_s[n]) state_d[n] = S_LOADING;
                     else if (timer_q[n] == INIT_TO) state_d[n] = S_ERROR;
        S_LOADING:   if (done_s[n]) state_d[n] = S_READY;
                     else if (timer_q[n] == DONE_TO) state_d[n] = S_ERROR;
        S_READY:     if (!done_s[n]) state_d[n] = S_ERROR;
        S_ERROR:     state_d[n] = S_ERROR;
        default:     state_d[n] = S_IDLE;
      endcase
      if (start[n]) state_d[n] = S_PROG;
      busy[n]    = (state_q[n] >= S_PROG) && (state_q[n] <= S_LOADING);
      err_set[n] = (state_d[n] == S_ERROR) && (state_q[n] != S_ERROR);
      // A restart re-enters PROG from PROG, so the start strobe also clears the timer.
      if (state_d[n] != state_q[n] || start[n]) timer_d[n] = '0;
      else if (busy[n])                         timer_d[n] = timer_q[n] + CNT_WIDTH'(1);
      else                                      timer_d[n] = '0;
    end
    err_flag_d = (err_flag_q & ~errclr) | err_set;
  end

  always_comb begin
    rd_data = 32'h0;
    case (wb.adr_i[3:2])
      2'd1: rd_data = {12'h0, busy, err_flag_q, init_s, done_s, gready_q};
      2'd2: rd_data = {28'h0, err_flag_q};
      2'd3: rd_data = {16'h0, 1'b0, state_q[3], 1'b0, state_q[2],
                       1'b0, state_q[1], 1'b0, state_q[0]};
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= {4{S_IDLE}};
      timer_q     <= '0;
      err_flag_q  <= 4'h0;
      program_b_q <= 4'hF;
      init_oe_q   <= 4'h0;
      gready_q    <= 4'h0;
      post_rst_q  <= 1'b1;
      ack_q       <= 1'b0;
      wr_q        <= 1'b0;
      dat_q       <= 32'h0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      err_flag_q <= err_flag_d;
      post_rst_q <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        program_b_q[n] <= (state_q[n] != S_PROG);
        init_oe_q[n]   <= (state_q[n] == S_INIT_HOLD);
        gready_q[n]    <= (state_q[n] == S_READY);
      end
      ack_q <= req;
      wr_q  <= req & wb.we_i;
      if (req) dat_q <= rd_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (req) begin
      wadr_q <= wb.adr_i[3:2];
      wdat_q <= wb.dat_i[3:0];
    end
  end

  assign program_b_o = program_b_q;
  assign init_b_oe_o = init_oe_q;
  assign gready_o    = gready_q;
  assign wb.dat_o    = dat_q;
  assign wb.ack_o    = ack_q;
  assign wb.err_o    = 1'b0;
  assign wb.rty_o    = 1'b0;
  assign unused_ok   = ^{wb.sel_i, wb.adr_i[1:0], wb.dat_i[31:4]};

endmodule

// File: tb/tb_glitc_config_ctrl.sv
// Self-checking bench for glitc_config_ctrl: register reads are scored against a
// queue of expected values, pin timing is checked cycle by cycle.
module tb_glitc_config_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] program_b_o, init_b_oe_o, init_b_i, done_i, gready_o;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  glitc_config_ctrl_if bus ();

  glitc_config_ctrl #(
    .PROG_CYCLES(64), .INIT_HOLD_CYCLES(64), .INIT_TIMEOUT(300),
    .DONE_TIMEOUT(2000), .CNT_WIDTH(24)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb(bus.slave),
    .program_b_o(program_b_o), .init_b_oe_o(init_b_oe_o), .init_b_i(init_b_i),
    .done_i(done_i), .gready_o(gready_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    logic got;
    got = 1'b0;
    rdat = 'x;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = adr; bus.dat_i = wdat; bus.sel_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.ack_o === 1'b1) begin
        got = 1'b1;
        rdat = bus.dat_o;
        break;
      end
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL wb_ack_timeout: ack=%b required=1", bus.ack_o);
    end
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wdat, dummy);
  endtask

  task automatic test_reset();
    logic [31:0] rd, ex;
    rst = 1'b1; done_i = 4'h0; init_b_i = 4'h0;
    repeat (4) tick();
    total++;
    if ({gready_o, program_b_o, init_b_oe_o, bus.ack_o} !== {4'h0, 4'hF, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_pins: got gready=%h progb=%h initoe=%h ack=%b required 0/F/0/0",
               gready_o, program_b_o, init_b_oe_o, bus.ack_o);
    end
    total++;
    if ({bus.dat_o, bus.err_o, bus.rty_o} !== 34'h0) begin
      bad++;
      $display("FAIL reset_bus: dat_o=%h err=%b rty=%b required 0", bus.dat_o, bus.err_o, bus.rty_o);
    end
    rst = 1'b0;
    repeat (3) tick();
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(32'h0);
      wb_xfer(1'b0, 4'(a * 4), 32'h0, rd);
      ex = exp_q.pop_front();
      total++;
      if (rd !== ex) begin
        bad++;
        $display("FAIL reset_read_adr%0d: got %h required %h", a, rd, ex);
      end
    end
  endtask

  task automatic test_program_ch0();
    int prog_low = 0, init_hi = 0, t_rel = -1, t_done = -1;
    logic prev_oe = 1'b0, others_bad = 1'b0, g3 = 1'bx, g4 = 1'bx;
    logic [31:0] rd, ex;
    wb_write(4'h0, 32'h1);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (program_b_o[0] === 1'b0) prog_low++;
      if (init_b_oe_o[0] === 1'b1) init_hi++;
      if (program_b_o[3:1] !== 3'b111 || init_b_oe_o[3:1] !== 3'b000 || gready_o[3:1] !== 3'b000)
        others_bad = 1'b1;
      if (prev_oe && !init_b_oe_o[0]) t_rel = i;
      prev_oe = init_b_oe_o[0];
      if (t_rel >= 0 && i == t_rel + 10) init_b_i[0] = 1'b1;
      if (t_rel >= 0 && i == t_rel + 110) begin done_i[0] = 1'b1; t_done = i; end
      if (t_done >= 0 && i == t_done + 3) g3 = gready_o[0];
      if (t_done >= 0 && i == t_done + 4) g4 = gready_o[0];
    end
    total++;
    if (prog_low != 64) begin bad++; $display("FAIL prog_width: got %0d required 64", prog_low); end
    total++;
    if (init_hi != 64) begin bad++; $display("FAIL init_hold_width: got %0d required 64", init_hi); end
    total++;
    if ({g3, g4} !== 2'b01) begin
      bad++;
      $display("FAIL gready_latency: got %b%b required 01", g3, g4);
    end
    total++;
    if (others_bad !== 1'b0) begin bad++; $display("FAIL other_channels: got disturbed required unchanged"); end
    exp_q.push_back(32'h0000_0111);
    wb_xfer(1'b0, 4'h4, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL ch0_status: got %h required %h", rd, ex); end
    exp_q.push_back(32'h0000_0005);
    wb_xfer(1'b0, 4'hC, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL ch0_state: got %h required %h", rd, ex); end
  endtask

  task automatic test_init_timeout();
    logic [31:0] rd, ex;
    wb_write(4'h0, 32'h4);
    repeat (395) tick();
    exp_q.push_back(32'h0000_0305);
    wb_xfer(1'b0, 4'hC, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL ch2_wait_init: got %h required %h", rd, ex); end
    repeat (60) tick();
    exp_q.push_back(32'h0000_4111);
    wb_xfer(1'b0, 4'h4, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL ch2_timeout_status: got %h required %h", rd, ex); end
    exp_q.push_back(32'h0000_0605);
    wb_xfer(1'b0, 4'hC, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL ch2_error_state: got %h required %h", rd, ex); end
    exp_q.push_back(32'h0000_0004);
    wb_xfer(1'b0, 4'h8, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL errflag_read: got %h required %h", rd, ex); end
    wb_write(4'h8, 32'h4);
    exp_q.push_back(32'h0000_0111);
    wb_xfer(1'b0, 4'h4, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL errclr_status: got %h required %h", rd, ex); end
  endtask

  task automatic test_done_loss();
    int n = -1;
    logic [31:0] rd, ex;
    init_b_i[1] = 1'b1;
    wb_write(4'h0, 32'h2);
    repeat (140) tick();
    done_i[1] = 1'b1;
    repeat (5) tick();
    total++;
    if (gready_o[1] !== 1'b1) begin bad++; $display("FAIL ch1_ready: gready1=%b required 1", gready_o[1]); end
    done_i[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (gready_o[1] === 1'b0 && n < 0) n = i;
    end
    total++;
    if (n < 0) begin bad++; $display("FAIL ch1_drop: gready1=%b required 0 within 4 cycles", gready_o[1]); end
    exp_q.push_back(32'h0000_0002);
    wb_xfer(1'b0, 4'h8, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL ch1_errflag: got %h required %h", rd, ex); end
  endtask

  task automatic test_back_to_back_restart();
    int cnt;
    logic [31:0] rd, ex;
    wb_write(4'h0, 32'h1);
    done_i[0] = 1'b0;
    repeat (140) tick();
    exp_q.push_back(32'h0000_0664);
    wb_xfer(1'b0, 4'hC, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL ch0_loading_state: got %h required %h", rd, ex); end
    repeat (5) tick();
    wb_write(4'h0, 32'hF);
    tick();
    total++;
    if (program_b_o !== 4'hF) begin bad++; $display("FAIL restart_lag: progb=%h required F", program_b_o); end
    tick();
    total++;
    if (program_b_o !== 4'h0) begin bad++; $display("FAIL restart_all: progb=%h required 0", program_b_o); end
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (program_b_o[0] !== 1'b0) break;
      cnt++;
    end
    total++;
    if (cnt != 64) begin bad++; $display("FAIL restart_timer: prog width %0d required 64", cnt); end
  endtask

  task automatic test_hot_reset();
    logic [31:0] rd, ex;
    logic pb_bad = 1'b0;
    wb_write(4'h0, 32'h8);
    done_i = 4'b1000;
    repeat (20) tick();
    total++;
    if (program_b_o[3] !== 1'b0) begin bad++; $display("FAIL ch3_in_prog: progb3=%b required 0", program_b_o[3]); end
    rst = 1'b1;
    tick();
    total++;
    if (program_b_o !== 4'hF) begin bad++; $display("FAIL reset_abort: progb=%h required F", program_b_o); end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    if (program_b_o !== 4'hF) pb_bad = 1'b1;
    tick();
    if (program_b_o !== 4'hF) pb_bad = 1'b1;
    total++;
    if (gready_o !== 4'b1000) begin bad++; $display("FAIL hot_reset_gready: got %b required 1000", gready_o); end
    repeat (5) begin tick(); if (program_b_o !== 4'hF) pb_bad = 1'b1; end
    total++;
    if (pb_bad !== 1'b0) begin bad++; $display("FAIL hot_reset_no_prog: progb pulsed required F"); end
    exp_q.push_back(32'h0000_0388);
    wb_xfer(1'b0, 4'h4, 32'h0, rd);
    ex = exp_q.pop_front();
    total++;
    if (rd !== ex) begin bad++; $display("FAIL hot_reset_status: got %h required %h", rd, ex); end
  endtask

  initial begin
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = 4'h0; bus.dat_i = 32'h0; bus.sel_i = 4'h0;
    rst = 1'b1; done_i = 4'h0; init_b_i = 4'h0;
    test_reset();
    test_program_ch0();
    test_init_timeout();
    test_done_loss();
    test_back_to_back_restart();
    test_hot_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
